// File: rtl/audio_clip_engine.sv
// audio_clip_engine: captures a clip of samples into block RAM and replays it
// at a fixed sample rate, one-shot or looped, with right-shift attenuation.
module audio_clip_engine #(
  parameter int SAMPLE_WIDTH      = 8,
  parameter int DEPTH             = 40000,
  parameter int CYCLES_PER_SAMPLE = 12500,
  parameter int ADDR_WIDTH        = $clog2(DEPTH),
  parameter int LEN_WIDTH         = $clog2(DEPTH + 1)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    record_in,
  input  logic                    play_in,
  input  logic                    stop_in,
  input  logic                    loop_in,
  input  logic [2:0]              volume_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid_in,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic                    sample_valid_out,
  output logic [1:0]              state_out,
  output logic [LEN_WIDTH-1:0]    length_out,
  output logic [ADDR_WIDTH-1:0]   addr_out,
  output logic                    full_out
);

  localparam int TICK_WIDTH = (CYCLES_PER_SAMPLE > 1) ? $clog2(CYCLES_PER_SAMPLE) : 1;
  localparam logic [TICK_WIDTH-1:0] TICK_LAST = TICK_WIDTH'(CYCLES_PER_SAMPLE - 1);
  localparam logic [LEN_WIDTH-1:0]  LEN_FULL  = LEN_WIDTH'(DEPTH);
  localparam logic [LEN_WIDTH-1:0]  LEN_LAST  = LEN_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_PLAY   = 2'd2
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [ADDR_WIDTH-1:0]   r_rd_addr;
  logic [LEN_WIDTH-1:0]    r_length;
  logic [TICK_WIDTH-1:0]   r_tick_cnt;
  logic                    r_rd_pend;
  logic [SAMPLE_WIDTH-1:0] r_mem_dout;
  logic [SAMPLE_WIDTH-1:0] r_sample_out;
  logic                    r_sample_valid_out;
  logic [SAMPLE_WIDTH-1:0] r_mem [DEPTH];

  logic w_flush;
  logic w_tick;
  logic w_last;
  logic w_wr_en;
  logic w_rd_en;

  always_comb begin
    w_flush = stop_in | record_in;
    w_tick  = (r_state == S_PLAY) && (r_tick_cnt == TICK_LAST);
    w_last  = (LEN_WIDTH'(r_rd_addr) == (r_length - LEN_WIDTH'(1)));
    w_wr_en = (r_state == S_RECORD) && sample_valid_in && !w_flush && (r_length < LEN_FULL);
    w_rd_en = w_tick && !w_flush;
  end

  // Clip storage: no reset so it maps onto block RAM; registered read.
  always_ff @(posedge clk_in) begin
    if (w_wr_en) begin
      r_mem[r_wr_addr] <= sample_in;
    end
    if (w_rd_en) begin
      r_mem_dout <= r_mem[r_rd_addr];
    end
  end

  // Control FSM with the playback output stage; stop/record squash any
  // in-flight read so no pulse appears after the command cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state            <= S_IDLE;
      r_wr_addr          <= '0;
      r_rd_addr          <= '0;
      r_length           <= '0;
      r_tick_cnt         <= '0;
      r_rd_pend          <= 1'b0;
      r_sample_out       <= '0;
      r_sample_valid_out <= 1'b0;
    end else begin
      r_rd_pend          <= w_rd_en;
      r_sample_valid_out <= 1'b0;
      if (r_rd_pend && !w_flush) begin
        r_sample_out       <= r_mem_dout >> volume_in;
        r_sample_valid_out <= 1'b1;
      end

      if (stop_in) begin
        r_state    <= S_IDLE;
        r_tick_cnt <= '0;
      end else if (record_in) begin
        r_state    <= S_RECORD;
        r_wr_addr  <= '0;
        r_length   <= '0;
        r_tick_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (play_in && (r_length != '0)) begin
              r_state    <= S_PLAY;
              r_rd_addr  <= '0;
              r_tick_cnt <= '0;
            end
          end
          S_RECORD: begin
            if (w_wr_en) begin
              r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
              r_length  <= r_length + LEN_WIDTH'(1);
              if (r_length == LEN_LAST) begin
                r_state <= S_IDLE;
              end
            end
          end
          S_PLAY: begin
            if (w_tick) begin
              r_tick_cnt <= '0;
              if (w_last) begin
                r_rd_addr <= '0;
                if (!loop_in) begin
                  r_state <= S_IDLE;
                end
              end else begin
                r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_WIDTH'(1);
            end
          end
          default: begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    addr_out = '0;
    case (r_state)
      S_RECORD: addr_out = r_wr_addr;
      S_PLAY:   addr_out = r_rd_addr;
      default:  addr_out = '0;
    endcase
  end

  assign sample_out       = r_sample_out;
  assign sample_valid_out = r_sample_valid_out;
  assign state_out        = r_state;
  assign length_out       = r_length;
  assign full_out         = (r_length == LEN_FULL);

endmodule
